// File: rtl/bin_to_disp_pkg.sv
// Package: bin_to_disp_pkg
// Purpose: shared types, constants and the leading-zero blanking helper for
//          the bin_to_disp binary-to-BCD display front end.
// Configuration: BIN_TO_DISP_LZB_EN selects the blank reset value (see BlankRst).
package bin_to_disp_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StUpdate = 2'd2
  } state_e;

  // Nibbles at or above this value get +3 before each shift
  localparam logic [3:0] BcdAdjTh = 4'd5;
  localparam logic [3:0] ErrAll   = 4'b1111;

`ifdef BIN_TO_DISP_LZB_EN
  // Reset shows a single "0" on digit 0
  localparam logic [3:0] BlankRst = 4'b1110;
`else
  localparam logic [3:0] BlankRst = 4'b0000;
`endif

  // Blank digits 3..1 that are zero with all higher digits zero, unless a dp
  // bit is set at that digit or any digit to its left.
  function automatic logic [3:0] lzb_mask(input logic [15:0] bcd, input logic [3:0] dp);
    logic [3:0] mask;
    logic       lead_zero;
    logic       guard;
    mask      = 4'b0000;
    lead_zero = 1'b1;
    guard     = 1'b0;
    for (int i = 3; i >= 1; i--) begin
      lead_zero = lead_zero & (bcd[4*i +: 4] == 4'd0);
      guard     = guard | dp[i];
      mask[i]   = lead_zero & ~guard;
    end
    return mask;
  endfunction

endpackage

// File: rtl/bin_to_disp_bcd_adj3.sv
// Module: bin_to_disp_bcd_adj3
// Purpose: combinational double-dabble nibble correction, out = (in >= 5) ? in + 3 : in.
// Ports:
//   nib_i  in  4  BCD nibble before correction
//   nib_o  out 4  corrected nibble
module bin_to_disp_bcd_adj3
  import bin_to_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  always_comb begin
    nib_o = (nib_i >= BcdAdjTh) ? nib_i + 4'd3 : nib_i;
  end

endmodule

// File: rtl/bin_to_disp.sv
// Module: bin_to_disp
// Purpose: iterative binary-to-BCD converter (shift/add-3 over Width clocks) that
//          produces registered digit, decimal-point, blank and error fields for a
//          4-digit display driver. Outputs hold until the next conversion completes.
// Parameters:
//   Width   binary input width
//   MaxVal  largest displayable value; larger inputs report overflow
// Ports:
//   clk_i      in   1      system clock
//   rst_ni     in   1      synchronous active-low reset
//   start_i    in   1      request conversion, sampled only when idle
//   bin_i      in   Width  unsigned value, sampled with start_i
//   ovf_i      in   1      upstream error, sampled with start_i
//   dp_pos_i   in   4      decimal-point mask, sampled with start_i
//   busy_o     out  1      high from the accepting edge until done
//   done_o     out  1      one-cycle pulse when outputs update
//   num0_o..num3_o out 4   BCD digits, num0_o least significant
//   dp_o       out  4      decimal-point mask
//   blank_o    out  4      per-digit blank mask
//   err_o      out  4      per-digit error mask
// Configuration: define BIN_TO_DISP_LZB_EN to enable leading-zero blanking.
module bin_to_disp
  import bin_to_disp_pkg::*;
#(
  parameter int unsigned Width  = 14,
  parameter int unsigned MaxVal = 9999
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [Width-1:0] bin_i,
  input  logic             ovf_i,
  input  logic [3:0]       dp_pos_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [3:0]       num0_o,
  output logic [3:0]       num1_o,
  output logic [3:0]       num2_o,
  output logic [3:0]       num3_o,
  output logic [3:0]       dp_o,
  output logic [3:0]       blank_o,
  output logic [3:0]       err_o
);

  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [Width-1:0]  bin_sr_q;
  logic [15:0]       bcd_q;
  logic              ovf_q;
  logic [3:0]        dp_pos_q;
  logic              busy_q;
  logic              done_q;
  logic [3:0]        num0_q, num1_q, num2_q, num3_q;
  logic [3:0]        dp_q, blank_q, err_q;

  logic [15:0]       bcd_adj;
  logic [Width+15:0] shift_d;
  logic [3:0]        blank_d;
  logic              in_ovf;

  for (genvar g = 0; g < 4; g++) begin : gen_adj
    bin_to_disp_bcd_adj3 u_adj (
      .nib_i (bcd_q[4*g +: 4]),
      .nib_o (bcd_adj[4*g +: 4])
    );
  end

  assign shift_d = {bcd_adj, bin_sr_q} << 1;

  // The range check is made on the raw input here so that the latched flag
  // reflects the latched value; bin_sr_q is consumed by the shifting.
  assign in_ovf = ovf_i | (32'(bin_i) > MaxVal);

  always_comb begin
    blank_d = 4'b0000;
`ifdef BIN_TO_DISP_LZB_EN
    blank_d = lzb_mask(bcd_q, dp_pos_q);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bin_sr_q <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      dp_pos_q <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      num0_q   <= 4'd0;
      num1_q   <= 4'd0;
      num2_q   <= 4'd0;
      num3_q   <= 4'd0;
      dp_q     <= 4'b0000;
      blank_q  <= BlankRst;
      err_q    <= 4'b0000;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            bin_sr_q <= bin_i;
            ovf_q    <= in_ovf;
            dp_pos_q <= dp_pos_i;
            bcd_q    <= '0;
            cnt_q    <= CntW'(Width - 1);
            busy_q   <= 1'b1;
            state_q  <= StShift;
          end
        end
        StShift: begin
          {bcd_q, bin_sr_q} <= shift_d;
          if (cnt_q == '0) begin
            state_q <= StUpdate;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StUpdate: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StIdle;
          if (ovf_q) begin
            err_q   <= ErrAll;
            blank_q <= 4'b0000;
            dp_q    <= 4'b0000;
            num0_q  <= 4'd0;
            num1_q  <= 4'd0;
            num2_q  <= 4'd0;
            num3_q  <= 4'd0;
          end else begin
            err_q   <= 4'b0000;
            blank_q <= blank_d;
            dp_q    <= dp_pos_q;
            num0_q  <= bcd_q[3:0];
            num1_q  <= bcd_q[7:4];
            num2_q  <= bcd_q[11:8];
            num3_q  <= bcd_q[15:12];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign num0_o  = num0_q;
  assign num1_o  = num1_q;
  assign num2_o  = num2_q;
  assign num3_o  = num3_q;
  assign dp_o    = dp_q;
  assign blank_o = blank_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_bin_to_disp.sv
module tb_bin_to_disp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic        ovf;
  logic [3:0]  dp_pos;
  logic        busy, done;
  logic [3:0]  num0, num1, num2, num3, dp, blank, err;

  int checks = 0;
  int errors = 0;

`ifdef BIN_TO_DISP_LZB_EN
  localparam bit Lzb = 1'b1;
`else
  localparam bit Lzb = 1'b0;
`endif

  always #5 clk = ~clk;

  bin_to_disp #(
    .Width  (14),
    .MaxVal (9999)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .bin_i    (bin),
    .ovf_i    (ovf),
    .dp_pos_i (dp_pos),
    .busy_o   (busy),
    .done_o   (done),
    .num0_o   (num0),
    .num1_o   (num1),
    .num2_o   (num2),
    .num3_o   (num3),
    .dp_o     (dp),
    .blank_o  (blank),
    .err_o    (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: decimal digits by division, blanking by scanning from the left.
  task automatic model(input int unsigned v, input bit o, input logic [3:0] dpm,
                       output logic [15:0] e_num, output logic [3:0] e_dp,
                       output logic [3:0] e_blank, output logic [3:0] e_err);
    bit zeros_so_far;
    bit protect;
    e_num = 16'h0; e_dp = 4'h0; e_blank = 4'h0; e_err = 4'h0;
    if (o || v > 9999) begin
      e_err = 4'hf;
    end else begin
      e_dp = dpm;
      for (int i = 0; i < 4; i++) e_num[4*i +: 4] = 4'((v / (10 ** i)) % 10);
      if (Lzb) begin
        zeros_so_far = 1'b1;
        protect      = 1'b0;
        for (int i = 3; i >= 1; i--) begin
          zeros_so_far = zeros_so_far && (((v / (10 ** i)) % 10) == 0);
          protect      = protect || dpm[i];
          e_blank[i]   = zeros_so_far && !protect;
        end
      end
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":done"}, done, 0);
    check({tag, ":num"}, {num3, num2, num1, num0}, 0);
    check({tag, ":dp"}, dp, 0);
    check({tag, ":err"}, err, 0);
    check({tag, ":blank"}, blank, Lzb ? 4'b1110 : 4'b0000);
  endtask

  // Run one conversion; inj > 0 pulses start with bin=7 at edge k+inj.
  task automatic run_conv(input int unsigned v, input bit o, input logic [3:0] dpm,
                          input int inj, input string tag);
    int          n;
    int          busy_cnt;
    bit          got;
    logic [15:0] e_num;
    logic [3:0]  e_dp, e_blank, e_err;
    model(v, o, dpm, e_num, e_dp, e_blank, e_err);
    @(posedge clk); #1;
    start = 1'b1; bin = 14'(v); ovf = o; dp_pos = dpm;
    @(posedge clk); #1;
    n = 0; got = 1'b0; busy_cnt = 0;
    while (!got && n < 40) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if (inj != 0 && n == inj - 1) begin
          start = 1'b1; bin = 14'd7; ovf = 1'b0;
        end else begin
          start = 1'b0; bin = 14'($urandom); ovf = 1'($urandom); dp_pos = 4'($urandom);
        end
        @(posedge clk); #1;
        n++;
      end
    end
    start = 1'b0;
    check({tag, ":done_seen"}, got, 1);
    check({tag, ":latency"}, n, 15);
    check({tag, ":busy_cycles"}, busy_cnt, 15);
    check({tag, ":busy_at_done"}, busy, 0);
    check({tag, ":num"}, {num3, num2, num1, num0}, e_num);
    check({tag, ":dp"}, dp, e_dp);
    check({tag, ":blank"}, blank, e_blank);
    check({tag, ":err"}, err, e_err);
    @(posedge clk); #1;
    check({tag, ":done_pulse"}, done, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    int unsigned v;
    bit o;
    logic [3:0] d;

    rst_n = 1'b0; start = 1'b0; bin = '0; ovf = 1'b0; dp_pos = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    run_conv(1234, 1'b0, 4'b0000, 0, "v1234");
    run_conv(42, 1'b0, 4'b0000, 0, "v42");
    run_conv(42, 1'b0, 4'b0100, 0, "v42_dp");
    run_conv(10000, 1'b0, 4'b0000, 0, "v10000");
    run_conv(5, 1'b1, 4'b0010, 0, "ovf_in");
    run_conv(9999, 1'b0, 4'b0001, 0, "v9999");
    run_conv(0, 1'b0, 4'b0000, 0, "v0");
    run_conv(16383, 1'b0, 4'b0000, 0, "v16383");
    run_conv(7, 1'b0, 4'b1000, 0, "v7_dp3");

    // Start while busy must be ignored and not queued
    run_conv(3056, 1'b0, 4'b0000, 3, "busy_start");
    dcount = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("busy_start:extra_done", dcount, 0);

    // Reset mid-conversion aborts with no done
    @(posedge clk); #1;
    start = 1'b1; bin = 14'd4321; ovf = 1'b0; dp_pos = 4'h0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset("mid_reset");
    rst_n = 1'b1;
    dcount = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("mid_reset:no_done", dcount, 0);
    run_conv(8, 1'b0, 4'b0000, 0, "after_reset");

    for (int i = 0; i < 16; i++) begin
      v = $urandom_range(0, 16383);
      if (i < 6) v = $urandom_range(0, 120);
      o = ($urandom_range(0, 7) == 0);
      d = (i < 8) ? 4'h0 : 4'($urandom);
      run_conv(v, o, d, 0, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
